// File: rtl/cdb_arb_bcast_pkg.sv
// Shared widths and result types for the buffered common data bus.
// Tag/ROB/data widths live here because the entry types are built from them.
package cdb_arb_bcast_pkg;

  localparam int PRF_ENTRY    = 64;
  localparam int DATA_W       = 32;
  localparam int ROB_ID_WIDTH = 5;
  localparam int TAG_W        = $clog2(PRF_ENTRY);

  typedef struct packed {
    logic                    wen;
    logic [TAG_W-1:0]        tag;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [DATA_W-1:0]       data;
  } cdb_entry_t;

  typedef struct packed {
    cdb_entry_t entry;
    logic [2:0] src;
  } cdb_lane_t;

  // Only ever called with idx < 2*n, so one conditional subtract wraps it.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_arb_bcast_src_fifo.sv
// Per-source result FIFO: registered head, push/pop in the same cycle keeps
// the count, clear empties it at the next edge.
module cdb_src_fifo import cdb_arb_bcast_pkg::*; #(
  parameter int  FIFO_DEPTH = 2,
  parameter type entry_t    = cdb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  entry_t push_data,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));

  // The top only pushes when not full and only pops when not empty.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cdb_arb_bcast.sv
// Buffered common data bus: per-source FIFOs, round-robin pick of up to
// NUM_LANES heads per cycle, broadcast to PRF/ROB/wakeup.
module cdb_arb_bcast import cdb_arb_bcast_pkg::*; #(
  parameter int NUM_SRC    = 8,
  parameter int NUM_LANES  = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [NUM_SRC-1:0]                         src_valid,
  output logic [NUM_SRC-1:0]                         src_ready,
  input  logic [NUM_SRC-1:0]                         src_wen,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]              src_tag,
  input  logic [NUM_SRC-1:0][ROB_ID_WIDTH-1:0]       src_rob_id,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]             src_data,
  output logic [NUM_LANES-1:0]                       cdb_valid,
  output logic [NUM_LANES-1:0]                       cdb_wen,
  output logic [NUM_LANES-1:0][TAG_W-1:0]            cdb_tag,
  output logic [NUM_LANES-1:0][ROB_ID_WIDTH-1:0]     cdb_rob_id,
  output logic [NUM_LANES-1:0][DATA_W-1:0]           cdb_data,
  output logic [NUM_LANES-1:0][$clog2(NUM_SRC)-1:0]  cdb_src,
  output logic [PRF_ENTRY-1:0]                       wakeup_vec,
  output logic [31:0]                                stall_cnt
);

  localparam int SRC_W = $clog2(NUM_SRC);

  cdb_entry_t         push_entry [NUM_SRC];
  cdb_entry_t         head       [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, empty, full;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  // Readiness comes only from registered occupancy, so a full FIFO stays
  // closed even in the cycle its head is being granted.
  assign src_ready = ~full & {NUM_SRC{~flush}};
  assign push      = src_valid & src_ready;
  assign stall_cnt = stall_cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push_entry[i] = '{wen: src_wen[i], tag: src_tag[i],
                             rob_id: src_rob_id[i], data: src_data[i]};

    cdb_src_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .entry_t    (cdb_entry_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data (push_entry[i]),
      .head      (head[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end

  always_comb begin
    int lane;
    int busy;
    int idx;
    lane        = 0;
    busy        = 0;
    idx         = 0;
    pop         = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid   = '0;
    cdb_wen     = '0;
    cdb_tag     = '0;
    cdb_rob_id  = '0;
    cdb_data    = '0;
    cdb_src     = '0;
    wakeup_vec  = '0;
    stall_cnt_d = stall_cnt_q;
    // Flush suppresses every grant, which also holds rr_ptr and blocks pops.
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = wrap_idx(int'(rr_ptr_q) + k, NUM_SRC);
      if (!empty[idx]) begin
        busy = busy + 1;
        if (lane < NUM_LANES && !flush) begin
          pop[idx]         = 1'b1;
          cdb_valid[lane]  = 1'b1;
          cdb_wen[lane]    = head[idx].wen;
          cdb_tag[lane]    = head[idx].tag;
          cdb_rob_id[lane] = head[idx].rob_id;
          cdb_data[lane]   = head[idx].data;
          cdb_src[lane]    = SRC_W'(idx);
          if (head[idx].wen) wakeup_vec[head[idx].tag] = 1'b1;
          rr_ptr_d = SRC_W'(wrap_idx(idx + 1, NUM_SRC));
          lane     = lane + 1;
        end
      end
    end
    if (!flush && busy > NUM_LANES && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_cdb_arb_bcast.sv
// Scoreboard bench for cdb_arb_bcast: stimulus queues expected broadcasts in
// hand-derived lane order, a negedge monitor pops and checks every lane.
module tb_cdb_arb_bcast;
  import cdb_arb_bcast_pkg::*;

  localparam int NS = 8;
  localparam int NL = 3;
  localparam int SW = $clog2(NS);

  logic clk = 1'b0;
  logic rst, flush;
  logic [NS-1:0]                   src_valid, src_ready, src_wen;
  logic [NS-1:0][TAG_W-1:0]        src_tag;
  logic [NS-1:0][ROB_ID_WIDTH-1:0] src_rob_id;
  logic [NS-1:0][DATA_W-1:0]       src_data;
  logic [NL-1:0]                   cdb_valid, cdb_wen;
  logic [NL-1:0][TAG_W-1:0]        cdb_tag;
  logic [NL-1:0][ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [NL-1:0][DATA_W-1:0]       cdb_data;
  logic [NL-1:0][SW-1:0]           cdb_src;
  logic [PRF_ENTRY-1:0]            wakeup_vec;
  logic [31:0]                     stall_cnt;

  typedef struct packed {
    logic [SW-1:0]           src;
    logic                    wen;
    logic [TAG_W-1:0]        tag;
    logic [ROB_ID_WIDTH-1:0] rob;
    logic [DATA_W-1:0]       data;
  } exp_t;

  exp_t                 exp_q [$];
  exp_t                 mon_e;
  logic [PRF_ENTRY-1:0] mon_wake;
  int                   tests_run    = 0;
  int                   tests_failed = 0;
  bit                   mon_en       = 1'b0;

  cdb_arb_bcast #(.NUM_SRC(NS), .NUM_LANES(NL), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_wen    (src_wen),
    .src_tag    (src_tag),
    .src_rob_id (src_rob_id),
    .src_data   (src_data),
    .cdb_valid  (cdb_valid),
    .cdb_wen    (cdb_wen),
    .cdb_tag    (cdb_tag),
    .cdb_rob_id (cdb_rob_id),
    .cdb_data   (cdb_data),
    .cdb_src    (cdb_src),
    .wakeup_vec (wakeup_vec),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    src_valid  = '0;
    src_wen    = '0;
    src_tag    = '0;
    src_rob_id = '0;
    src_data   = '0;
  endtask

  task automatic applyStimulus(input int s, input logic wen,
                               input logic [TAG_W-1:0] tag,
                               input logic [ROB_ID_WIDTH-1:0] rob,
                               input logic [DATA_W-1:0] data,
                               input bit queue_it);
    src_valid[s]  = 1'b1;
    src_wen[s]    = wen;
    src_tag[s]    = tag;
    src_rob_id[s] = rob;
    src_data[s]   = data;
    if (queue_it)
      exp_q.push_back('{src: SW'(s), wen: wen, tag: tag, rob: rob, data: data});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Every valid lane must match the next expected result in lane order;
  // idle lanes must be all-zero and wakeup_vec must equal the OR of wen tags.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_wake = '0;
      for (int k = 0; k < NL; k++) begin
        if (cdb_valid[k] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checkOutput($sformatf("unexpected_bcast_lane%0d", k), 64'(cdb_valid[k]), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput($sformatf("lane%0d_src", k),  64'(cdb_src[k]),    64'(mon_e.src));
            checkOutput($sformatf("lane%0d_wen", k),  64'(cdb_wen[k]),    64'(mon_e.wen));
            checkOutput($sformatf("lane%0d_tag", k),  64'(cdb_tag[k]),    64'(mon_e.tag));
            checkOutput($sformatf("lane%0d_rob", k),  64'(cdb_rob_id[k]), 64'(mon_e.rob));
            checkOutput($sformatf("lane%0d_data", k), 64'(cdb_data[k]),   64'(mon_e.data));
            if (mon_e.wen) mon_wake[mon_e.tag] = 1'b1;
          end
        end else begin
          checkOutput($sformatf("lane%0d_idle", k),
                      64'({cdb_valid[k], cdb_wen[k], cdb_tag[k], cdb_rob_id[k],
                           cdb_data[k], cdb_src[k]}), 64'd0);
        end
      end
      checkOutput("wakeup_vec", 64'(wakeup_vec), 64'(mon_wake));
    end
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clear_inputs();
    step();
    step();
    rst    = 1'b0;
    mon_en = 1'b1;

    mid();
    checkOutput("reset_src_ready", 64'(src_ready), 64'hFF);
    checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);

    // Single result from source 2, visible one cycle after acceptance.
    step(); applyStimulus(2, 1'b1, 7, 3, 32'hDEADBEEF, 1'b1);
    step(); clear_inputs();
    mid();  checkOutput("single_wakeup7", 64'(wakeup_vec[7]), 64'd1);
    repeat (2) step();

    // All eight sources at once: {0,1,2}, {3,4,5}, {6,7}; two stalled cycles.
    do_reset();
    step();
    for (int s = 0; s < NS; s++)
      applyStimulus(s, 1'b1, TAG_W'(10 + s), ROB_ID_WIDTH'(s), 32'hA000_0000 + s, 1'b1);
    step(); clear_inputs();
    repeat (3) step();
    mid();  checkOutput("burst_stall_cnt", 64'(stall_cnt), 64'd2);
    // rr_ptr wrapped to 0, so source 0 must come out ahead of source 7.
    step();
    applyStimulus(0, 1'b1, 20, 20, 32'h0000_0C00, 1'b1);
    applyStimulus(7, 1'b1, 27, 27, 32'h0000_0C07, 1'b1);
    step(); clear_inputs();
    repeat (2) step();

    // Source 5 streams alone: never back-pressured, in-order delivery.
    for (int i = 0; i < 6; i++) begin
      step();
      applyStimulus(5, 1'b1, TAG_W'(30 + i), ROB_ID_WIDTH'(i), 32'h5500_0000 + i, 1'b1);
      mid();
      checkOutput("stream_src_ready5", 64'(src_ready[5]), 64'd1);
    end
    step(); clear_inputs();
    repeat (2) step();

    // Source 0 backs up behind sources 1-3 and its held valid waits for ready.
    do_reset();
    step(); applyStimulus(0, 1'b1, 40, 0, 32'h0A00_0000, 1'b1);
    step(); clear_inputs();
    applyStimulus(1, 1'b1, 41, 1, 32'h0B00_0001, 1'b1);
    applyStimulus(2, 1'b1, 42, 2, 32'h0B00_0002, 1'b1);
    applyStimulus(3, 1'b1, 43, 3, 32'h0B00_0003, 1'b1);
    applyStimulus(0, 1'b1, 44, 4, 32'h0A00_0001, 1'b1);
    mid();  checkOutput("backup_ready0_c1", 64'(src_ready[0]), 64'd1);
    step(); clear_inputs(); applyStimulus(0, 1'b1, 45, 5, 32'h0A00_0002, 1'b1);
    mid();  checkOutput("backup_ready0_c2", 64'(src_ready[0]), 64'd1);
    step(); clear_inputs(); applyStimulus(0, 1'b1, 46, 6, 32'h0A00_0003, 1'b1);
    mid();  checkOutput("backup_ready0_full", 64'(src_ready[0]), 64'd0);
    step();
    mid();  checkOutput("backup_ready0_back", 64'(src_ready[0]), 64'd1);
    step(); clear_inputs();
    repeat (2) step();
    mid();  checkOutput("backup_stall_cnt", 64'(stall_cnt), 64'd1);

    // Flush with four FIFOs loaded: nothing broadcast, nothing kept, rr held at 7.
    do_reset();
    step(); applyStimulus(6, 1'b1, 47, 7, 32'h0600_0006, 1'b1);
    step(); clear_inputs();
    step();
    step();
    for (int s = 2; s < 6; s++)
      applyStimulus(s, 1'b1, TAG_W'(48 + s), ROB_ID_WIDTH'(s), 32'hF000_0000 + s, 1'b0);
    step(); clear_inputs(); flush = 1'b1;
    applyStimulus(1, 1'b1, 60, 1, 32'h0100_0001, 1'b0);
    mid();
    checkOutput("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("flush_src_ready", 64'(src_ready), 64'd0);
    step(); flush = 1'b0; clear_inputs();
    applyStimulus(0, 1'b1, 61, 8, 32'h0000_0061, 1'b1);
    applyStimulus(4, 1'b1, 62, 9, 32'h0400_0062, 1'b1);
    mid();
    checkOutput("flush_no_stale", 64'(cdb_valid), 64'd0);
    checkOutput("flush_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("flush_ready_back", 64'(src_ready), 64'hFF);
    step(); clear_inputs();
    repeat (2) step();

    // rr_ptr=5: store (wen=0, tag 9), duplicate tag 5, then tag 0 next cycle.
    step();
    applyStimulus(6, 1'b0, 9, 10, 32'h0600_0009, 1'b1);
    applyStimulus(0, 1'b1, 5, 11, 32'h0000_0005, 1'b1);
    applyStimulus(1, 1'b1, 5, 12, 32'h0100_0005, 1'b1);
    applyStimulus(2, 1'b1, 0, 13, 32'h0200_0000, 1'b1);
    step(); clear_inputs();
    mid();
    checkOutput("store_wen", 64'(cdb_wen[0]), 64'd0);
    checkOutput("store_no_wakeup9", 64'(wakeup_vec[9]), 64'd0);
    checkOutput("dup_wakeup5", 64'(wakeup_vec[5]), 64'd1);
    step();
    mid();  checkOutput("tag0_wakeup", 64'(wakeup_vec[0]), 64'd1);
    repeat (2) step();
    mid();  checkOutput("final_stall_cnt", 64'(stall_cnt), 64'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cdb_arb_bcast.md
Name: cdb_arb_bcast

Overview:
Parametrised, buffered common data bus that replaces the fixed one-slot-per-FU combinational CDB. Each of NUM_SRC functional-unit result channels pushes into a small per-source FIFO through a valid/ready handshake. A round-robin arbiter picks up to NUM_LANES FIFO heads per cycle and broadcasts them to the PRF write ports, the ROB completion ports and the reservation-station wakeup bitmap. A flush input clears all in-flight results.

Parameters:
- NUM_SRC, 8, number of FU result channels (ALU x3, MUL, DIV, MEM_LD, MEM_ST, BRANCH).
- NUM_LANES, 3, broadcast lanes per cycle (PRF write ports); 1 <= NUM_LANES <= NUM_SRC.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 1.
- PRF_ENTRY, 64, physical registers; tag width is $clog2(PRF_ENTRY).
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict/jal flush; discards all buffered results.
- src_valid  in  [NUM_SRC]  FU result valid.
- src_ready  out  [NUM_SRC]  FIFO can accept this cycle.
- src_wen  in  [NUM_SRC]  result writes the PRF (0 for stores and conditional branches).
- src_tag  in  [NUM_SRC][$clog2(PRF_ENTRY)]  destination physical register.
- src_rob_id  in  [NUM_SRC][ROB_ID_WIDTH]  ROB index.
- src_data  in  [NUM_SRC][DATA_W]  result data.
- cdb_valid  out  [NUM_LANES]  lane carries a result (ROB completion).
- cdb_wen  out  [NUM_LANES]  lane writes the PRF.
- cdb_tag  out  [NUM_LANES][$clog2(PRF_ENTRY)]  PRF write tag.
- cdb_rob_id  out  [NUM_LANES][ROB_ID_WIDTH]  ROB index.
- cdb_data  out  [NUM_LANES][DATA_W]  PRF write data.
- cdb_src  out  [NUM_LANES][$clog2(NUM_SRC)]  originating channel (monitor use).
- wakeup_vec  out  [PRF_ENTRY]  one bit per tag broadcast with wen this cycle.
- stall_cnt  out  32  saturating count of cycles in which at least one non-empty head was not granted.

Behaviour:
- Reset: all FIFOs empty, rr_ptr=0, stall_cnt=0. All cdb_*, wakeup_vec and cdb_src are 0. src_ready is 1 for every source when FIFO_DEPTH>=1.
- src_ready[i] = (count[i] != FIFO_DEPTH) && !flush. It depends only on registered count, never on the same-cycle pop.
- Push on a src_valid & src_ready clock edge. src_valid while not ready is ignored. Producers must hold their result; there is no drop.
- Latency: a result accepted in cycle t is eligible for broadcast in cycle t+1 at the earliest. There is no same-cycle bypass.
- Arbitration (combinational from FIFO heads): scan sources rr_ptr, rr_ptr+1, ... mod NUM_SRC. The k-th non-empty head found goes to lane k, for k < NUM_LANES. Lanes without a grant output all zeros.
- Granted heads pop at the clock edge.
- rr_ptr update: becomes (last granted index + 1) mod NUM_SRC. It is unchanged when nothing is granted.
- Push and pop on the same FIFO in the same cycle: count unchanged, order preserved. FIFO pointers wrap mod FIFO_DEPTH.
- Unused lane fields are zero, not don't-care.
- wakeup_vec[cdb_tag[k]] = 1 for every lane with cdb_valid & cdb_wen. Tag 0 is broadcast like any other tag; masking x0 is the consumer's job.
- Duplicate tags across lanes are legal; wakeup_vec ORs them.
- Flush in cycle t:
  - cdb_valid and wakeup_vec are forced to 0 in cycle t.
  - No push is accepted.
  - All FIFOs are emptied at the edge.
  - rr_ptr is held, and stall_cnt does not count cycle t.
- rst has priority over flush. Reset mid-operation discards all FIFO contents.
- stall_cnt increments when (number of non-empty heads) > NUM_LANES and !flush. It saturates at 32'hFFFF_FFFF.

Decomposition:
- In rv32i_types: cdb_entry_t (wen, tag, rob_id, data) and cdb_lane_t (cdb_entry_t plus src index).
- Sub-module cdb_src_fifo: parameters FIFO_DEPTH and entry type. Ports: push, pop, head, empty, full, clear. It is instantiated NUM_SRC times via generate.
- The arbiter and lane muxing stay in the top module.

Test Plan:
- Reset, then src 2 pushes {wen=1, tag=7, rob=3, data=0xDEADBEEF} in cycle 1 -> in cycle 2 lane 0 carries it, wakeup_vec[7]=1, lanes 1-2 zero, cdb_src[0]=2.
- NUM_LANES=3, all 8 sources push once in the same cycle -> cycles +1/+2/+3 broadcast sources {0,1,2}, {3,4,5}, {6,7}. stall_cnt ends at 2, and rr_ptr=0 afterwards.
- Source 5 pushes every cycle with no competition, FIFO_DEPTH=2 -> src_ready stays 1, one broadcast per cycle, no loss, in-order data.
- Hold 4 sources busy so source 0 backs up -> src_ready[0] falls after 2 accepts. The held valid is accepted once ready returns; order is preserved.
- Fill 3 FIFOs, assert flush for 1 cycle -> cdb_valid=0 that cycle, src_ready all 0. The next cycle all FIFOs are empty, no stale broadcast follows, and rr_ptr is unchanged.
- Store channel pushes wen=0, tag=9 -> cdb_valid=1, cdb_wen=0, wakeup_vec[9]=0.
